// File: rtl/vga_sync_driver_pkg.sv
// Shared timing constants and colour-bar palette
// for the 640x480@60Hz VGA sync driver.
package vga_sync_driver_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam logic SYNC_POL = 1'b0;
  localparam int   BAR_W    = 80;

  typedef logic [5:0] rgb_t;

  localparam rgb_t C_WHITE   = 6'b111111;
  localparam rgb_t C_YELLOW  = 6'b111100;
  localparam rgb_t C_CYAN    = 6'b001111;
  localparam rgb_t C_GREEN   = 6'b001100;
  localparam rgb_t C_MAGENTA = 6'b110011;
  localparam rgb_t C_RED     = 6'b110000;
  localparam rgb_t C_BLUE    = 6'b000011;
  localparam rgb_t C_BLACK   = 6'b000000;

  function automatic rgb_t bar_colour(
    input logic [2:0] bar
  );
    rgb_t c;
    unique case (bar)
      3'd0: c = C_WHITE;
      3'd1: c = C_YELLOW;
      3'd2: c = C_CYAN;
      3'd3: c = C_GREEN;
      3'd4: c = C_MAGENTA;
      3'd5: c = C_RED;
      3'd6: c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_driver_if.sv
// VGA output bundle: pixel clock, counters,
// syncs and colour towards the board DAC.
interface vga_sync_driver_if;
  import vga_sync_driver_pkg::*;

  logic             pixel_clk;
  logic [CNT_W-1:0] cnt_h;
  logic [CNT_W-1:0] cnt_v;
  logic             vga_sync_h;
  logic             vga_sync_v;
  rgb_t             vga_rgb;

  modport master (
    output pixel_clk,
    output cnt_h,
    output cnt_v,
    output vga_sync_h,
    output vga_sync_v,
    output vga_rgb
  );

  modport slave (
    input pixel_clk,
    input cnt_h,
    input cnt_v,
    input vga_sync_h,
    input vga_sync_v,
    input vga_rgb
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Colour-bar test pattern: eight equal bars over
// the active area, black during blanking.
module vga_pattern_gen #(
  parameter int H_ACTIVE = vga_sync_driver_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_sync_driver_pkg::V_ACTIVE,
  parameter int BAR_W    = vga_sync_driver_pkg::BAR_W
) (
  input  logic [vga_sync_driver_pkg::CNT_W-1:0] cnt_h,
  input  logic [vga_sync_driver_pkg::CNT_W-1:0] cnt_v,
  output vga_sync_driver_pkg::rgb_t             vga_rgb
);

  logic [2:0] bar;
  logic       active;

  // Threshold chain instead of a divider by BAR_W.
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(cnt_h) >= k * BAR_W) begin
        bar = 3'(k);
      end
    end
  end

  assign active = (int'(cnt_h) < H_ACTIVE)
               && (int'(cnt_v) < V_ACTIVE);

  assign vga_rgb = active
    ? vga_sync_driver_pkg::bar_colour(bar)
    : '0;

endmodule

// File: rtl/vga_sync_driver.sv
// VGA timing generator: clk/2 pixel enable,
// h/v counters, sync decode and test pattern.
module vga_sync_driver #(
  parameter int   H_ACTIVE = vga_sync_driver_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_sync_driver_pkg::H_FP,
  parameter int   H_SYNC   = vga_sync_driver_pkg::H_SYNC,
  parameter int   H_BP     = vga_sync_driver_pkg::H_BP,
  parameter int   V_ACTIVE = vga_sync_driver_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_sync_driver_pkg::V_FP,
  parameter int   V_SYNC   = vga_sync_driver_pkg::V_SYNC,
  parameter int   V_BP     = vga_sync_driver_pkg::V_BP,
  parameter logic SYNC_POL = vga_sync_driver_pkg::SYNC_POL,
  parameter int   BAR_W    = vga_sync_driver_pkg::BAR_W
) (
  input  logic              clk,
  input  logic              rst,
  vga_sync_driver_if.master vga
);

  localparam int CW = vga_sync_driver_pkg::CNT_W;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int HS1 = HS0 + H_SYNC - 1;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = VS0 + V_SYNC - 1;

  logic          pixel_clk_q;
  logic [CW-1:0] cnt_h_q;
  logic [CW-1:0] cnt_v_q;
  logic          pix_en;
  logic          h_wrap;
  logic          v_wrap;
  logic          in_hs;
  logic          in_vs;

  assign pix_en = pixel_clk_q;

  // >= so a corrupted count still falls back to 0.
  assign h_wrap = int'(cnt_h_q) >= HT - 1;
  assign v_wrap = int'(cnt_v_q) >= VT - 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_clk_q <= 1'b0;
      cnt_h_q     <= '0;
      cnt_v_q     <= '0;
    end else begin
      pixel_clk_q <= ~pixel_clk_q;
      if (pix_en) begin
        if (h_wrap) begin
          cnt_h_q <= '0;
          cnt_v_q <= v_wrap ? '0 : cnt_v_q + CW'(1);
        end else begin
          cnt_h_q <= cnt_h_q + CW'(1);
        end
      end
    end
  end

  assign in_hs = (int'(cnt_h_q) >= HS0)
              && (int'(cnt_h_q) <= HS1);
  assign in_vs = (int'(cnt_v_q) >= VS0)
              && (int'(cnt_v_q) <= VS1);

  assign vga.pixel_clk  = pixel_clk_q;
  assign vga.cnt_h      = cnt_h_q;
  assign vga.cnt_v      = cnt_v_q;
  assign vga.vga_sync_h = in_hs ? SYNC_POL : ~SYNC_POL;
  assign vga.vga_sync_v = in_vs ? SYNC_POL : ~SYNC_POL;

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BAR_W    (BAR_W)
  ) u_pattern (
    .cnt_h   (cnt_h_q),
    .cnt_v   (cnt_v_q),
    .vga_rgb (vga.vga_rgb)
  );

endmodule

// File: tb/tb_vga_sync_driver.sv
// Bench: full-size instance for line-level timing,
// shrunken-timing instance for frame wrap and vsync.
module tb_vga_sync_driver;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 480, VF = 10, VS = 2, VB = 33;
  localparam int BW = 80;
  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 2;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1;
  localparam int SBW = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   vs_fall [$];
  logic vs_prev = 1'b1;

  vga_sync_driver_if vd ();
  vga_sync_driver_if vs ();

  vga_sync_driver dut (
    .clk (clk),
    .rst (rst),
    .vga (vd)
  );

  vga_sync_driver #(
    .H_ACTIVE (SHA), .H_FP (SHF),
    .H_SYNC   (SHS), .H_BP (SHB),
    .V_ACTIVE (SVA), .V_FP (SVF),
    .V_SYNC   (SVS), .V_BP (SVB),
    .SYNC_POL (1'b0), .BAR_W (SBW)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .vga (vs)
  );

  always #10 clk = ~clk;

  // k = clk edges since reset was last sampled high
  always @(posedge clk) begin
    cyc <= cyc + 1;
    k   <= rst ? 0 : k + 1;
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)",
               name, act, exp, k);
    end
  endtask

  function automatic int m_rgb(int h, int v,
                               int ha, int va, int bw);
    int tbl [8];
    tbl = '{6'b111111, 6'b111100, 6'b001111,
            6'b001100, 6'b110011, 6'b110000,
            6'b000011, 6'b000000};
    if (h >= ha || v >= va) return 0;
    return tbl[h / bw];
  endfunction

  function automatic int m_sync(int c, int st, int len);
    return (c >= st && c < st + len) ? 0 : 1;
  endfunction

  task automatic cmp_all(string tag, int kk,
    int pc, int ch, int cv, int sh, int sv, int rgb,
    int ha, int hf, int hs, int hb,
    int va, int vf, int vsn, int vb, int bw);
    int ht, vt, p, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vsn + vb;
    p  = kk / 2;
    h  = p % ht;
    v  = (p / ht) % vt;
    chk({tag, " pixel_clk"}, pc, kk % 2);
    chk({tag, " cnt_h"}, ch, h);
    chk({tag, " cnt_v"}, cv, v);
    chk({tag, " sync_h"}, sh, m_sync(h, ha + hf, hs));
    chk({tag, " sync_v"}, sv, m_sync(v, va + vf, vsn));
    chk({tag, " rgb"}, rgb, m_rgb(h, v, va > 0 ? ha : 0,
                                  va, bw));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_all("big", k, int'(vd.pixel_clk),
        int'(vd.cnt_h), int'(vd.cnt_v),
        int'(vd.vga_sync_h), int'(vd.vga_sync_v),
        int'(vd.vga_rgb),
        HA, HF, HS, HB, VA, VF, VS, VB, BW);
      cmp_all("small", k, int'(vs.pixel_clk),
        int'(vs.cnt_h), int'(vs.cnt_v),
        int'(vs.vga_sync_h), int'(vs.vga_sync_v),
        int'(vs.vga_rgb),
        SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SBW);
      if (vs_prev && !vs.vga_sync_v && !rst)
        vs_fall.push_back(cyc);
      vs_prev = vs.vga_sync_v;
    end
  end

  task automatic wait_k(int n);
    while (k < n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst pixel_clk", int'(vd.pixel_clk), 0);
    chk("rst cnt_v", int'(vd.cnt_v), 0);
    chk("rst sync_h", int'(vd.vga_sync_h), 1);
    chk("rst rgb", int'(vd.vga_rgb), 6'b111111);
    rst    = 1'b0;
    chk_en = 1'b1;
    wait_k(1);
    chk("rise pixel_clk", int'(vd.pixel_clk), 1);
    chk("rise cnt_h", int'(vd.cnt_h), 0);
    wait_k(2);
    chk("step cnt_h", int'(vd.cnt_h), 1);
    wait_k(158);
    chk("rgb h79", int'(vd.vga_rgb), 6'b111111);
    wait_k(160);
    chk("rgb h80", int'(vd.vga_rgb), 6'b111100);
    wait_k(960);
    chk("rgb h480", int'(vd.vga_rgb), 6'b000011);
    wait_k(1120);
    chk("rgb h560", int'(vd.vga_rgb), 6'b000000);
    wait_k(1278);
    chk("rgb h639", int'(vd.vga_rgb), 6'b000000);
    wait_k(1310);
    chk("sync_h h655", int'(vd.vga_sync_h), 1);
    wait_k(1312);
    chk("sync_h h656", int'(vd.vga_sync_h), 0);
    wait_k(1502);
    chk("sync_h h751", int'(vd.vga_sync_h), 0);
    wait_k(1504);
    chk("sync_h h752", int'(vd.vga_sync_h), 1);
    wait_k(1598);
    chk("pre-wrap cnt_h", int'(vd.cnt_h), 799);
    chk("pre-wrap cnt_v", int'(vd.cnt_v), 0);
    wait_k(1600);
    chk("wrap cnt_h", int'(vd.cnt_h), 0);
    chk("wrap cnt_v", int'(vd.cnt_v), 1);
    wait_k(2200);
    chk("pre-rst cnt_h", int'(vd.cnt_h), 300);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst pixel_clk", int'(vd.pixel_clk), 0);
    chk("midrst cnt_h", int'(vd.cnt_h), 0);
    chk("midrst cnt_v", int'(vd.cnt_v), 0);
    chk("midrst sync_h", int'(vd.vga_sync_h), 1);
    chk("midrst sync_v", int'(vd.vga_sync_v), 1);
    rst = 1'b0;
    wait_k(1);
    chk("resume pixel_clk", int'(vd.pixel_clk), 1);
    wait_k(2);
    chk("resume cnt_h", int'(vd.cnt_h), 1);
    wait_k(20);
    chk_en = 1'b0;
    n_chk++;
    if (vs_fall.size() < 2) begin
      n_err++;
      $display("FAIL vsync period: %0d edges seen, need 2",
               vs_fall.size());
    end else if (vs_fall[1] - vs_fall[0] != 2 * SHT * SVT) begin
      n_err++;
      $display("FAIL vsync period: got %0d expected %0d",
               vs_fall[1] - vs_fall[0], 2 * SHT * SVT);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
